matrix_entry_loader: RTL and testbench

//  Upstream stage of the matrix multiplier: the user keys in the DIM x DIM operand matrices
//  A then B from switches, one Q10.6 element at a time. Writes each element into the A/B

---
 rtl/matrix_entry_loader_if.sv | 35 +++
 rtl/matrix_entry_loader.sv | 120 ++++++++++++
 tb/tb_matrix_entry_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_entry_loader_if.sv
// Purpose: bundles the switch/key inputs and RAM/status outputs of the matrix entry loader.
// Latency: n/a (wiring only).
// Backpressure: none; the loader is driven by a human operator and a write-only RAM port.
interface matrix_entry_loader_if #(
   parameter int INT_W  = 10,
   parameter int FRAC_W = 6,
   parameter int ADDR_W = 5
);
   localparam int DATA_W = INT_W + FRAC_W;

   logic              start;
   logic              enter;
   logic [INT_W-1:0]  sw;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              we_a;
   logic              we_b;
   logic              busy;
   logic              load_done;
   logic              cur_mat;
   logic [ADDR_W-1:0] cur_idx;
   logic              phase;

   // Operator / testbench side: drives the keys and switches, observes RAM and status.
   modport master (
      output start, enter, sw,
      input  addr, wdata, we_a, we_b, busy, load_done, cur_mat, cur_idx, phase
   );

   // Loader side.
   modport slave (
      input  start, enter, sw,
      output addr, wdata, we_a, we_b, busy, load_done, cur_mat, cur_idx, phase
   );
endinterface

// File: rtl/matrix_entry_loader.sv
// Purpose: keys in DIM x DIM Q-format matrices A then B (integer then fraction per element) into A/B RAMs.
// Latency: key press seen 2 clk after first sample; RAM strobe the cycle after the fraction press.
// Backpressure: none; key presses outside GET_INT/GET_FRAC and start while busy are dropped.
module matrix_entry_loader #(
   parameter int DIM    = 3,
   parameter int INT_W  = 10,
   parameter int FRAC_W = 6,
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   matrix_entry_loader_if.slave bus
);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DIM*DIM - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_INT  = 3'd1,
      GET_FRAC = 3'd2,
      WRITE    = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                cur_mat_q, cur_mat_d;
   logic [INT_W-1:0]    int_latch_q, int_latch_d;
   logic [FRAC_W-1:0]   frac_latch_q, frac_latch_d;
   logic                s1_q, s1_d;
   logic                s2_q, s2_d;
   logic                s3_q, s3_d;
   logic                enter_pulse;

   // Key synchroniser chain; a press is the rising edge seen between the 2nd and 3rd flop.
   always_comb begin
      s1_d        = bus.enter;
      s2_d        = s1_q;
      s3_d        = s2_q;
      enter_pulse = s2_q & ~s3_q;
   end

   // All state, counters, latches and synchroniser flops; reset drops straight back to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cur_mat_q    <= 1'b0;
         int_latch_q  <= '0;
         frac_latch_q <= '0;
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cur_mat_q    <= cur_mat_d;
         int_latch_q  <= int_latch_d;
         frac_latch_q <= frac_latch_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
      end
   end

   // Next-state logic; start wins over a coincident key press because IDLE/DONE never look at the key.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cur_mat_d    = cur_mat_q;
      int_latch_d  = int_latch_q;
      frac_latch_d = frac_latch_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d   = GET_INT;
               idx_d     = '0;
               cur_mat_d = 1'b0;
            end
         end
         GET_INT: begin
            if (enter_pulse) begin
               int_latch_d = bus.sw[INT_W-1:0];
               state_d     = GET_FRAC;
            end
         end
         GET_FRAC: begin
            if (enter_pulse) begin
               frac_latch_d = bus.sw[FRAC_W-1:0];
               state_d      = WRITE;
            end
         end
         WRITE: begin
            if (idx_q != LAST_IDX) begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = GET_INT;
            end else if (!cur_mat_q) begin
               idx_d     = '0;
               cur_mat_d = 1'b1;
               state_d   = GET_INT;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs: address and data are held stable around the single-cycle strobe in WRITE.
   always_comb begin
      bus.addr      = idx_q;
      bus.wdata     = {int_latch_q, frac_latch_q};
      bus.we_a      = (state_q == WRITE) && !cur_mat_q;
      bus.we_b      = (state_q == WRITE) &&  cur_mat_q;
      bus.busy      = (state_q == GET_INT) || (state_q == GET_FRAC) || (state_q == WRITE);
      bus.load_done = (state_q == DONE);
      bus.cur_mat   = cur_mat_q;
      bus.cur_idx   = idx_q;
      bus.phase     = (state_q == GET_FRAC);
   end
endmodule

// File: tb/tb_matrix_entry_loader.sv
// Purpose: directed self-checking bench for matrix_entry_loader.
// Latency: key press lands 3 clk after enter is raised; strobe one clk after the fraction lands.
// Backpressure: n/a.
module tb_matrix_entry_loader;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   both_hi;

   matrix_entry_loader_if #(.INT_W(10), .FRAC_W(6), .ADDR_W(5)) bus ();

   matrix_entry_loader #(.DIM(3), .INT_W(10), .FRAC_W(6), .ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Write log captured from the RAM strobes, sampled away from the active edge.
   logic        log_mat[$];
   logic [4:0]  log_addr[$];
   logic [15:0] log_dat[$];

   always @(negedge clk) begin
      if (bus.we_a && bus.we_b) both_hi++;
      if (bus.we_a || bus.we_b) begin
         log_mat.push_back(bus.we_b);
         log_addr.push_back(bus.addr);
         log_dat.push_back(bus.wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Key press: switches set, key held for 'hold' cycles, then released long enough to re-arm.
   task automatic press(input logic [9:0] v, input int hold);
      @(negedge clk);
      bus.sw    = v;
      bus.enter = 1'b1;
      repeat (hold) @(negedge clk);
      bus.enter = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [9:0] val_of(input int k);
      return 10'(k * 53 + 3);
   endfunction

   initial begin
      logic [9:0] v;
      int         base;
      int         n;
      checks    = 0;
      failures  = 0;
      both_hi   = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.enter = 1'b0;
      bus.sw    = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_done",  32'(bus.load_done), 32'd0);
      chk("rst_addr",  32'(bus.addr),      32'd0);
      chk("rst_wdata", 32'(bus.wdata),     32'd0);
      chk("rst_phase", 32'(bus.phase),     32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Key press in IDLE is ignored
      press(10'd7, 3);
      chk("idle_busy",  32'(bus.busy),  32'd0);
      chk("idle_phase", 32'(bus.phase), 32'd0);
      chk("idle_wdata", 32'(bus.wdata), 32'd0);
      chk("idle_nowr",  32'(log_mat.size()), 32'd0);

      // Single element 5 + 32/64 -> 0x0160 at A[0]
      pulse_start();
      chk("st_busy", 32'(bus.busy),    32'd1);
      chk("st_idx",  32'(bus.cur_idx), 32'd0);
      chk("st_mat",  32'(bus.cur_mat), 32'd0);
      press(10'd5, 3);
      chk("el_phase1", 32'(bus.phase), 32'd1);
      press(10'd32, 3);
      chk("el_nwr",   32'(log_mat.size()), 32'd1);
      chk("el_mat",   32'(log_mat[0]),     32'd0);
      chk("el_addr",  32'(log_addr[0]),    32'd0);
      chk("el_wdata", 32'(log_dat[0]),     32'h0160);
      chk("el_phase0", 32'(bus.phase),     32'd0);
      chk("el_idx",   32'(bus.cur_idx),    32'd1);

      // Three more A elements, then abort mid-entry
      for (int k = 1; k < 4; k++) begin
         press(val_of(k), 3);
         press(val_of(k), 3);
      end
      chk("ab_nwr", 32'(log_mat.size()), 32'd4);
      press(10'h3FF, 3);
      chk("ab_phase_pre", 32'(bus.phase), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ab_busy",  32'(bus.busy),  32'd0);
      chk("ab_addr",  32'(bus.addr),  32'd0);
      chk("ab_wdata", 32'(bus.wdata), 32'd0);
      chk("ab_phase", 32'(bus.phase), 32'd0);
      chk("ab_idx",   32'(bus.cur_idx), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("ab_nostrobe", 32'(log_mat.size()), 32'd4);
      pulse_start();
      press(10'd9, 3);
      press(10'd9, 3);
      chk("ab_nwr2",  32'(log_mat.size()), 32'd5);
      chk("ab_mat2",  32'(log_mat[4]),     32'd0);
      chk("ab_addr2", 32'(log_addr[4]),    32'd0);
      chk("ab_dat2",  32'(log_dat[4]),     {16'd0, 10'd9, 6'd9});

      // Full load of 18 elements from a clean reset
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      base = log_mat.size();
      pulse_start();
      for (int k = 0; k < 18; k++) begin
         v = val_of(k);
         if (k == 5) begin
            // start during GET_FRAC must not disturb idx/cur_mat
            press(v, 3);
            pulse_start();
            chk("ign_idx",   32'(bus.cur_idx), 32'd5);
            chk("ign_mat",   32'(bus.cur_mat), 32'd0);
            chk("ign_phase", 32'(bus.phase),   32'd1);
            press(v, 3);
         end else if (k == 10) begin
            // long hold gives exactly one press
            n = log_mat.size();
            press(v, 200);
            chk("hold_phase", 32'(bus.phase),    32'd1);
            chk("hold_nwr",   32'(log_mat.size()), 32'(n));
            press(v, 3);
         end else begin
            press(v, 3);
            press(v, 3);
         end
         if (k == 16) chk("pre_done", 32'(bus.load_done), 32'd0);
      end
      chk("full_nwr", 32'(log_mat.size() - base), 32'd18);
      for (int i = 0; i < 18; i++) begin
         v = val_of(i);
         if (base + i < log_mat.size()) begin
            chk($sformatf("full_mat%0d", i),  32'(log_mat[base+i]),  (i >= 9) ? 32'd1 : 32'd0);
            chk($sformatf("full_addr%0d", i), 32'(log_addr[base+i]), 32'(i % 9));
            chk($sformatf("full_dat%0d", i),  32'(log_dat[base+i]),  {16'd0, v, v[5:0]});
         end
      end
      chk("done_flag", 32'(bus.load_done), 32'd1);
      chk("done_busy", 32'(bus.busy),      32'd0);

      // Key press in DONE ignored, start restarts on A[0]
      n = log_mat.size();
      press(10'd1, 3);
      chk("done_key_flag", 32'(bus.load_done), 32'd1);
      chk("done_key_nwr",  32'(log_mat.size()), 32'(n));
      pulse_start();
      chk("rs_done", 32'(bus.load_done), 32'd0);
      chk("rs_busy", 32'(bus.busy),      32'd1);
      chk("rs_idx",  32'(bus.cur_idx),   32'd0);
      chk("rs_mat",  32'(bus.cur_mat),   32'd0);

      chk("we_exclusive", 32'(both_hi), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
